// File: rtl/trifid_pkg.sv
// Shared types and constants for the trifid block cipher.
package trifid_pkg;
  typedef logic [1:0] digit_t;

  typedef struct packed {
    digit_t layer;
    digit_t row;
    digit_t col;
  } triple_t;

  typedef enum logic {ST_FILL, ST_EMIT} state_t;

  localparam logic [7:0] DOT_ASCII  = 8'h2E;
  localparam triple_t    DOT_TRIPLE = 6'b100010;
  localparam int         PERIOD_MAX = 16;

  // sel 0/1/2 selects layer/row/col of a stored letter
  function automatic digit_t pick(triple_t t, logic [1:0] sel);
    case (sel)
      2'd0:    return t.layer;
      2'd1:    return t.row;
      default: return t.col;
    endcase
  endfunction
endpackage

// File: rtl/trifid_sym_lut.sv
// Combinational symbol tables: ASCII -> (layer,row,col) and back.
module trifid_sym_lut
  import trifid_pkg::*;
(
  input  logic [7:0] ascii_i,
  output triple_t    triple_o,
  input  triple_t    triple_i,
  output logic [7:0] ascii_o
);
  // Letters A..Z in order; '.' is DOT_TRIPLE
  localparam triple_t TAB [26] = '{
    6'b101001, 6'b000110, 6'b001001, 6'b010101, 6'b100000, 6'b000000,
    6'b010001, 6'b100101, 6'b101010, 6'b000100, 6'b100110, 6'b011000,
    6'b010010, 6'b100001, 6'b001000, 6'b011001, 6'b101000, 6'b000001,
    6'b001010, 6'b011010, 6'b100100, 6'b010000, 6'b010110, 6'b000101,
    6'b000010, 6'b010100
  };

  logic [7:0] ofs;
  assign ofs = ascii_i - 8'h41;

  always_comb begin
    triple_o = DOT_TRIPLE;
    if (ascii_i >= 8'h41 && ascii_i <= 8'h5A) triple_o = TAB[ofs[4:0]];
  end

  always_comb begin
    ascii_o = DOT_ASCII;
    for (int i = 0; i < 26; i++)
      if (triple_i == TAB[i]) ascii_o = 8'(8'h41 + i);
  end
endmodule

// File: rtl/trifid_block_cipher.sv
// Block trifid transposition over a valid/ready character stream.
// Optional decrypt datapath and port enabled by TRIFID_DECRYPT_EN.
module trifid_block_cipher
  import trifid_pkg::*;
#(
  parameter int PERIOD = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
`ifdef TRIFID_DECRYPT_EN
  input  logic       decrypt,
`endif
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last
);
  localparam int NW    = $clog2(PERIOD + 1);
  localparam int DEPTH = 1 << NW;
  typedef logic [NW-1:0] idx_t;

  state_t     state_q, state_d;
  logic       rdy_q;
  idx_t       n_q, n_d, e_q, e_d, ek_q, ek_d, ek_nx;
  logic [1:0] epl_q, epl_d, epl_nx;
  triple_t    buf_q [DEPTH];

  triple_t    in_tri, out_tri, enc_tri;
  logic [7:0] out_ascii;
  logic       in_acc, out_acc, close;
  idx_t       n_inc, n_last;

  trifid_sym_lut u_lut (
    .ascii_i  (in_data),
    .triple_o (in_tri),
    .triple_i (out_tri),
    .ascii_o  (out_ascii)
  );

  assign in_acc    = in_valid && rdy_q;
  assign n_inc     = n_q + idx_t'(1);
  assign n_last    = n_q - idx_t'(1);
  assign close     = in_acc && ((n_inc == idx_t'(PERIOD)) || in_last);
  assign in_ready  = rdy_q;
  assign out_valid = (state_q == ST_EMIT);
  assign out_last  = out_valid && (e_q == n_last);
  assign out_data  = out_valid ? out_ascii : 8'h00;
  assign out_acc   = out_valid && out_ready;

  always_ff @(posedge clk)
    if (in_acc) buf_q[n_q] <= in_tri;

  // Encrypt pointer is flat index 3j held as (plane, k); three wrap steps per output
  always_comb begin
    logic [1:0] pl;
    idx_t       k;
    logic [5:0] acc;
    pl  = epl_q;
    k   = ek_q;
    acc = '0;
    for (int i = 0; i < 3; i++) begin
      acc = {acc[3:0], pick(buf_q[k], pl)};
      if (k == n_last) begin
        pl = pl + 2'd1;
        k  = '0;
      end else begin
        k = k + idx_t'(1);
      end
    end
    enc_tri = acc;
    epl_nx  = pl;
    ek_nx   = k;
  end

`ifdef TRIFID_DECRYPT_EN
  // Decrypt pointers are flat indices j, n+j, 2n+j held as (k, digit)
  typedef logic [NW+1:0] dptr_t;
  logic    dec_q, dec_d;
  dptr_t   dp_q [3];
  dptr_t   dp_d [3];
  triple_t dec_tri;

  function automatic dptr_t dstep(dptr_t p);
    if (p[1:0] == 2'd2) return {p[NW+1:2] + idx_t'(1), 2'd0};
    return {p[NW+1:2], p[1:0] + 2'd1};
  endfunction

  always_comb begin
    dec_d = dec_q;
    for (int i = 0; i < 3; i++) dp_d[i] = dp_q[i];
    if (in_acc) begin
      if (n_q == '0) dec_d = decrypt;
      dp_d[1] = dstep(dp_q[1]);
      dp_d[2] = dstep(dstep(dp_q[2]));
    end else if (out_acc) begin
      for (int i = 0; i < 3; i++) dp_d[i] = out_last ? '0 : dstep(dp_q[i]);
    end
    dec_tri = {pick(buf_q[dp_q[0][NW+1:2]], dp_q[0][1:0]),
               pick(buf_q[dp_q[1][NW+1:2]], dp_q[1][1:0]),
               pick(buf_q[dp_q[2][NW+1:2]], dp_q[2][1:0])};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dec_q <= 1'b0;
      for (int i = 0; i < 3; i++) dp_q[i] <= '0;
    end else begin
      dec_q <= dec_d;
      for (int i = 0; i < 3; i++) dp_q[i] <= dp_d[i];
    end
  end

  assign out_tri = dec_q ? dec_tri : enc_tri;
`else
  assign out_tri = enc_tri;
`endif

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    e_d     = e_q;
    epl_d   = epl_q;
    ek_d    = ek_q;
    case (state_q)
      ST_FILL: if (in_acc) begin
        n_d = n_inc;
        if (close) state_d = ST_EMIT;
      end
      default: if (out_acc) begin
        if (out_last) begin
          state_d = ST_FILL;
          n_d     = '0;
          e_d     = '0;
          epl_d   = '0;
          ek_d    = '0;
        end else begin
          e_d   = e_q + idx_t'(1);
          epl_d = epl_nx;
          ek_d  = ek_nx;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      rdy_q   <= 1'b0;
      n_q     <= '0;
      e_q     <= '0;
      epl_q   <= '0;
      ek_q    <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == ST_FILL);
      n_q     <= n_d;
      e_q     <= e_d;
      epl_q   <= epl_d;
      ek_q    <= ek_d;
    end
  end
endmodule

// File: tb/tb_trifid_block_cipher.sv
// Directed scoreboard bench for trifid_block_cipher (PERIOD=5).
module tb_trifid_block_cipher;
  localparam int PERIOD = 5;

  logic       clk, rst_n, in_valid, in_ready, in_last;
  logic       out_valid, out_ready, out_last, decrypt;
  logic [7:0] in_data, out_data;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [8:0]  exp_q [$];
  logic [7:0]  blk [16];
  // digits of A..Z then '.', three per symbol
  string TAB = "332123132222311111212322333121323231213312131232331112133233321211223122113221313";

  trifid_block_cipher #(.PERIOD(PERIOD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
`ifdef TRIFID_DECRYPT_EN
    .decrypt   (decrypt),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [8:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $error("FAIL out_extra: observed data=%02h last=%0b expected no output", out_data, out_last);
      end else begin
        e = exp_q.pop_front();
        assert ({out_last, out_data} === e) else begin
          n_err++;
          $error("FAIL out_char: observed last=%0b data=%02h expected last=%0b data=%02h",
                 out_last, out_data, e[8], e[7:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input string s);
    for (int i = 0; i < s.len(); i++) blk[i] = s[i];
  endtask

  task automatic expect_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back({(i == s.len() - 1), s[i]});
  endtask

  // Reference encrypt: build the flat digit sequence, regroup in threes
  task automatic expect_enc(input int n);
    int t [48];
    int sym, hit;
    logic [7:0] ch;
    for (int k = 0; k < n; k++) begin
      sym = (blk[k] >= 8'h41 && blk[k] <= 8'h5A) ? int'(blk[k]) - 65 : 26;
      for (int d = 0; d < 3; d++) t[d*n + k] = int'(TAB[3*sym + d]) - 48;
    end
    for (int j = 0; j < n; j++) begin
      hit = 26;
      for (int s = 0; s < 27; s++)
        if (int'(TAB[3*s]) - 48 == t[3*j] && int'(TAB[3*s+1]) - 48 == t[3*j+1] &&
            int'(TAB[3*s+2]) - 48 == t[3*j+2]) hit = s;
      ch = (hit < 26) ? 8'(65 + hit) : 8'h2E;
      exp_q.push_back({(j == n - 1), ch});
    end
  endtask

  task automatic send(input int len, input bit last_end);
    int w;
    for (int i = 0; i < len; i++) begin
      in_valid = 1'b1;
      in_data  = blk[i];
      in_last  = last_end && (i == len - 1);
      w = 0;
      while (!in_ready && w < 50) begin step(); w++; end
      if (w == 50) chk("in_ready_timeout", in_ready, 1);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 200) begin step(); w++; end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    chk("ready_after_block", in_ready, 1);
  endtask

  initial begin
    int len;
    bit lst;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    out_ready = 1'b1; decrypt = 1'b0;
    repeat (3) step();
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_last", out_last, 0);
    rst_n = 1'b1;
    step();
    chk("in_ready_rise", in_ready, 1);

    load("HELLO"); expect_str("AGSUF"); send(5, 0);
    chk("latency_valid", out_valid, 1);
    chk("latency_data", out_data, "A");
    chk("emit_in_ready", in_ready, 0);
    drain();

    load("AB"); expect_str(".W"); send(2, 1); drain();
    load("Q"); expect_str("Q"); send(1, 1); drain();
    blk[0] = 8'h61; expect_str("."); send(1, 1); drain();

    load("TRIFI"); expect_enc(5); send(5, 0);
    chk("bp_first_valid", out_valid, 1);
    step();
    out_ready = 1'b0; in_valid = 1'b1; in_data = "Z";
    repeat (4) begin
      step();
      chk("bp_hold_data", out_data, exp_q[0][7:0]);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain();

    load("CIPHE"); expect_enc(5); send(5, 1); drain();
    step(); step();
    chk("no_second_close", out_valid, 0);

    for (int b = 0; b < 3; b++) begin
      len = $urandom_range(1, PERIOD);
      for (int i = 0; i < len; i++) blk[i] = 8'($urandom_range(32, 126));
      lst = (len < PERIOD) ? 1'b1 : 1'($urandom_range(0, 1));
      expect_enc(len); send(len, lst); drain();
    end

`ifdef TRIFID_DECRYPT_EN
    decrypt = 1'b1; load("AGSUF"); expect_str("HELLO"); send(5, 0);
    decrypt = 1'b0; drain();
    load("HELLO"); expect_str("AGSUF"); send(5, 0); drain();
`endif

    load("WORLD"); expect_enc(5); send(5, 0);
    step(); step();
    chk("mid_emit_consumed", exp_q.size(), 3);
    rst_n = 1'b0;
    step();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_ready", in_ready, 0);
    exp_q.delete();
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", in_ready, 1);
    load("AB"); expect_str(".W"); send(2, 1); drain();

    step(); step();
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_idle", out_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
